div_seq: RTL and testbench

Iterative 32-bit signed/unsigned divider for the MIPS core's EX stage. It takes DIV/DIVU operands from the ID/EX register and runs a radix-2 restoring division over 32 cycles. While it runs it holds the pipeline via a stall request, then presents quotient/remainder with a one-cycle HI/LO write strobe. It is the multi-cycle path feeding the HI/LO register alongside the combinational ALU.

---
 rtl/div_seq_pkg.sv | 16 +
 rtl/div_step.sv | 29 ++
 rtl/div_seq.sv | 119 +++++++++++
 tb/tb_div_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared defines for the EX-stage divider
package div_seq_pkg;

    localparam int          RegDataWidth  = 32;
    localparam logic        RstEnable     = 1'b1;
    localparam logic        WriteEnable   = 1'b1;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;

    localparam int              DivStateWidth = 2;
    localparam logic [1:0]      DivIdle       = 2'b00;
    localparam logic [1:0]      DivRun        = 2'b01;
    localparam logic [1:0]      DivDone       = 2'b10;

    localparam int              DivCntWidth   = 5;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift the next dividend bit into the remainder and try subtracting the divisor.
    // rem < divisor_mag on entry, so a failed trial leaves a value that fits in WIDTH bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_mag};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative signed/unsigned divider feeding HI/LO
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = RegDataWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             stall_req,
    output logic             done,
    output logic             we_hilo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [DivStateWidth-1:0] state;
    logic [DivCntWidth-1:0]   cnt;
    logic [WIDTH-1:0]         rem;
    logic [WIDTH-1:0]         quo;
    logic [WIDTH-1:0]         divisor_mag;
    logic                     neg_q;
    logic                     neg_r;

    logic [WIDTH-1:0]         step_rem;
    logic [WIDTH-1:0]         step_quo;
    logic [WIDTH-1:0]         dividend_abs;
    logic [WIDTH-1:0]         divisor_abs;
    logic                     last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem),
        .quo         (quo),
        .divisor_mag (divisor_mag),
        .rem_next    (step_rem),
        .quo_next    (step_quo)
    );

    // Operand magnitudes for DIV; DIVU uses the raw values.
    always_comb begin
        dividend_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_abs  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
        last_step    = (cnt == DivCntWidth'(WIDTH - 1));
    end

    assign we_hilo = done;

    // Control FSM, iteration datapath and registered result/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state       <= DivIdle;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_mag <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            stall_req   <= 1'b0;
            done        <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            case (state)
                DivIdle: begin
                    done <= 1'b0;
                    if (start && !annul) begin
                        if (divisor == '0) begin
                            // Divide-by-zero bypasses the iteration entirely.
                            state  <= DivDone;
                            done   <= 1'b1;
                            lo_out <= '1;
                            hi_out <= dividend;
                        end else begin
                            state       <= DivRun;
                            stall_req   <= 1'b1;
                            cnt         <= '0;
                            rem         <= '0;
                            quo         <= dividend_abs;
                            divisor_mag <= divisor_abs;
                            neg_q       <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r       <= signed_div & dividend[WIDTH-1];
                        end
                    end
                end
                DivRun: begin
                    if (annul) begin
                        state     <= DivIdle;
                        stall_req <= 1'b0;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + 1'b1;
                        if (last_step) begin
                            state     <= DivDone;
                            stall_req <= 1'b0;
                            done      <= 1'b1;
                            lo_out    <= neg_q ? -step_quo : step_quo;
                            hi_out    <= neg_r ? -step_rem : step_rem;
                        end
                    end
                end
                DivDone: begin
                    state <= DivIdle;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= DivIdle;
                    stall_req <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall_req;
    logic        done;
    logic        we_hilo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } exp_t;

    vec_t tbl[11];
    exp_t sb[$];

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .stall_req  (stall_req),
        .done       (done),
        .we_hilo    (we_hilo),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one operation, wait for done within a bound, compare with the scoreboard head.
    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b);
        int   n;
        int   stalls;
        bit   got;
        exp_t e;
        @(negedge clk);
        start = 1'b1; signed_div = sd; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        stalls = 0;
        got = 1'b0;
        n = 1;
        while (n <= 60 && !got) begin
            if (stall_req) stalls++;
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout: no done for %0d/%0d within 60 cycles", a, b);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: done with no expected entry");
        end else begin
            e = sb.pop_front();
            chk("lo_out", lo_out, e.lo);
            chk("hi_out", hi_out, e.hi);
            chk("latency", 32'(n), 32'(e.lat));
            chk("stall_cycles", 32'(stalls), 32'(e.lat - 1));
            chk("we_hilo", {31'b0, we_hilo}, 32'd1);
            @(negedge clk);
            chk("done_one_cycle", {31'b0, done}, 32'd0);
        end
    endtask

    task automatic push_model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        exp_t e;
        x = sd ? longint'($signed(a)) : longint'({32'b0, a});
        y = sd ? longint'($signed(b)) : longint'({32'b0, b});
        q = x / y;
        r = x % y;
        e.lo  = q[31:0];
        e.hi  = r[31:0];
        e.lat = 33;
        sb.push_back(e);
    endtask

    task automatic watch_idle(input string name, input int cycles);
        int dones, stalls;
        dones = 0; stalls = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (stall_req) stalls++;
        end
        chk({name, "_no_done"}, 32'(dones), 32'd0);
        chk({name, "_no_stall"}, 32'(stalls), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        int   dones, stalls, first_done;

        tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33};
        tbl[1]  = '{1'b1, 32'hFFFFFFF9,  32'h2,         32'hFFFFFFFD,  32'hFFFFFFFF,  33};
        tbl[2]  = '{1'b1, 32'h7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'h1,         33};
        tbl[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         33};
        tbl[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  33};
        tbl[5]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1};
        tbl[6]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  33};
        tbl[7]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1};
        tbl[8]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         33};
        tbl[9]  = '{1'b0, 32'd7,         32'hFFFFFFFF,  32'd0,         32'd7,         33};
        tbl[10] = '{1'b1, 32'd0,         32'd5,         32'd0,         32'd0,         33};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0; annul = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we", {31'b0, we_hilo}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            e.lo = tbl[i].lo; e.hi = tbl[i].hi; e.lat = tbl[i].lat;
            sb.push_back(e);
            run_op(tbl[i].sd, tbl[i].a, tbl[i].b);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 0) rb = 32'd3;
            push_model(i[0], ra, rb);
            run_op(i[0], ra, rb);
        end

        // Known result in HI/LO before the annulled operation.
        e.lo = 32'd14; e.hi = 32'd2; e.lat = 33;
        sb.push_back(e);
        run_op(1'b0, 32'd100, 32'd7);

        // Annul on the 10th RUN cycle.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        chk("pre_annul_stall", {31'b0, stall_req}, 32'd1);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_stall", {31'b0, stall_req}, 32'd0);
        chk("annul_done", {31'b0, done}, 32'd0);
        chk("annul_lo_kept", lo_out, 32'd14);
        chk("annul_hi_kept", hi_out, 32'd2);
        watch_idle("annul", 40);
        chk("annul_lo_still", lo_out, 32'd14);

        e.lo = 32'd3; e.hi = 32'd0; e.lat = 33;
        sb.push_back(e);
        run_op(1'b0, 32'd9, 32'd3);

        // Annul in IDLE beats start.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        watch_idle("idle_annul", 5);

        // Reset on the 20th RUN cycle.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 20; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_stall", {31'b0, stall_req}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_we", {31'b0, we_hilo}, 32'd0);
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        watch_idle("midrst", 40);

        // Start held high through RUN and into DONE: exactly one acceptance.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
        dones = 0; stalls = 0; first_done = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (done) begin
                dones++;
                if (first_done == 0) first_done = n;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(dones), 32'd1);
        chk("held_stall_count", 32'(stalls), 32'd32);
        chk("held_latency", 32'(first_done), 32'd33);
        chk("held_lo", lo_out, 32'd14);
        chk("held_hi", hi_out, 32'd2);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
